// File: rtl/riscv_zero_prefetch.sv
// rtl/riscv_zero_prefetch.sv - Instruction prefetch queue fed by a single-outstanding fetch FSM
module riscv_zero_prefetch #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] pc_in,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [ILEN-1:0] mem_rdata,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [ILEN-1:0] d_inst_data,
    output logic [XLEN-1:0] d_pc
);
    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [ILEN-1:0] inst_q [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic [XLEN-1:0] drop_addr;
    logic            push;
    logic            pop;

    // A redirect cancels both the response being written and the pop being taken.
    assign d_valid     = (count != '0);
    assign pop         = d_valid && d_ready && !branch_taken;
    assign push        = (state == REQ) && mem_ack && !branch_taken;
    assign mem_req     = (state != IDLE);
    assign mem_addr    = (state == DROP) ? drop_addr : fetch_pc;
    assign d_inst_data = d_valid ? inst_q[rd_ptr] : '0;
    assign d_pc        = d_valid ? pc_q[rd_ptr] : '0;

    always_comb begin
        count_nxt = count;
        if (branch_taken) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // A new request is only issued when its response is guaranteed a free slot.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        case (state)
            IDLE: begin
                if (branch_taken) begin
                    fetch_pc_nxt = pc_in;
                    state_nxt    = REQ;
                end else if (count_nxt < FULL) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    fetch_pc_nxt = pc_in;
                    state_nxt    = mem_ack ? REQ : DROP;
                end else if (mem_ack) begin
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                    state_nxt    = (count_nxt < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (branch_taken) begin
                    fetch_pc_nxt = pc_in;
                end
                if (mem_ack) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            fetch_pc <= fetch_pc_nxt;
            // The squashed request keeps presenting its original address until acked.
            if ((state == REQ) && branch_taken && !mem_ack) begin
                drop_addr <= fetch_pc;
            end
            if (branch_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= fetch_pc;
            inst_q[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: doc/riscv_zero_prefetch.md
RISCV_ZERO_PREFETCH -- requirements
Module: riscv_zero_prefetch

Interface
REQ-001 Parameter XLEN, 64, address/PC width in bits.
REQ-002 Parameter ILEN, 32, instruction width in bits.
REQ-003 Parameter DEPTH, 4, instruction queue entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, 0, fetch address after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clk.
REQ-007 branch_taken  input  1  redirect request from later stage.
REQ-008 pc_in  input  XLEN  redirect target, sampled when branch_taken=1.
REQ-009 mem_req  output  1  instruction memory read request.
REQ-010 mem_addr  output  XLEN  read address, valid while mem_req=1.
REQ-011 mem_ack  input  1  memory accepted request and mem_rdata valid this cycle.
REQ-012 mem_rdata  input  ILEN  instruction word, valid when mem_ack=1.
REQ-013 d_valid  output  1  queue head holds a valid instruction for decode.
REQ-014 d_ready  input  1  decode accepts head this cycle.
REQ-015 d_inst_data  output  ILEN  head instruction word.
REQ-016 d_pc  output  XLEN  PC of head instruction.

Function
REQ-017 Queue is a DEPTH-entry circular FIFO of {pc, inst}; read/write pointers wrap modulo DEPTH; occupancy count is clog2(DEPTH+1) bits.
REQ-018 Fetch FSM states: IDLE (no request), REQ (mem_req=1, awaiting ack), DROP (mem_req=1, awaiting ack of squashed request).
REQ-019 IDLE->REQ when no redirect pending and count+pops_this_cycle leaves a free slot for the response; mem_addr=fetch_pc.
REQ-020 In REQ/DROP, mem_req and mem_addr hold stable until mem_ack=1; no request is withdrawn.
REQ-021 mem_ack in REQ: push {fetch_pc, mem_rdata}; fetch_pc += 4 modulo 2^XLEN; go REQ again next cycle if a slot remains, else IDLE.
REQ-022 mem_ack may arrive in the same cycle mem_req first rises (zero-wait memory); one transfer per cycle max, one outstanding request max.
REQ-023 d_valid = (count != 0); pop occurs when d_valid && d_ready; d_inst_data/d_pc show head entry combinationally from queue storage.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance; push into a full queue is impossible by REQ-019.
REQ-025 branch_taken=1: queue flushed (count, pointers to 0) next cycle; fetch_pc <= pc_in; pop in that cycle has no effect.
REQ-026 branch_taken in REQ without mem_ack: go DROP; the eventual response is discarded, then go REQ at pc_in.
REQ-027 branch_taken with mem_ack same cycle: response discarded, next state REQ with mem_addr=pc_in.
REQ-028 branch_taken in DROP: update fetch_pc to newest pc_in, remain DROP.
REQ-029 pc_in low two bits used as-is; no alignment check.
REQ-030 Throughput: with mem_ack tied high and d_ready high, one instruction delivered per cycle sustained.

Reset
REQ-031 While reset=0: mem_req=0, mem_addr=RESET_PC, d_valid=0, d_inst_data=0, d_pc=0, FSM=IDLE, count=0, fetch_pc=RESET_PC.
REQ-032 Assertion mid-request abandons the transaction; any late mem_ack after release while IDLE is ignored.
REQ-033 First mem_req asserted in the first clk cycle after reset release; d_valid no earlier than the cycle after first mem_ack.

Verification
REQ-034 Zero-wait memory preloaded 0x0=ABCD1234, 0x4=ABCD5678, 0x8=08080808, d_ready=1 -> d_inst_data ABCD1234, ABCD5678, 08080808 on consecutive cycles with d_pc 0x0, 0x4, 0x8.
REQ-035 d_ready=0, DEPTH=4, mem_ack=1 -> exactly 4 pushes, mem_req drops to 0, d_valid=1 held on 0x0; raise d_ready -> fetch resumes at 0x10 without gap or duplicate.
REQ-036 branch_taken=1 with pc_in=0x1C while queue holds 3 entries -> d_valid=0 next cycle, next mem_addr=0x1C, next delivered d_pc=0x1C with data CAB1DAB1.
REQ-037 3-cycle-latency memory, branch to 0x08 during outstanding request to 0x4 -> data for 0x4 never appears on d_inst_data; next request mem_addr=0x08.
REQ-038 reset driven low while in REQ with 2 queued entries -> all outputs at REQ-031 values same cycle; after release first mem_addr=RESET_PC.
REQ-039 RESET_PC=0xFFFF_FFFF_FFFF_FFF8, zero-wait -> d_pc sequence ...FFF8, ...FFFC, 0x0 (wrap).
